// File: rtl/mem_arb_pkg.sv
// Shared encodings, default sizes and helpers for the memory access arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_TIMEOUT = 15;

    // Encoding shared with the memory FSM, which idles at 2'b11.
    typedef enum logic [1:0] {
        IDLE   = 2'b11,
        GRANT  = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Bits needed to index v items; never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter bundled together.
interface mem_access_arbiter_if #(
    parameter int unsigned N_REQ  = mem_arb_pkg::DEF_N_REQ,
    parameter int unsigned ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DEF_DATA_W
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_rw;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    err;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_valid;
    logic                    mem_rw;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    mem_ready;

    // Arbiter view.
    modport slave (
        input  req, req_rw, req_addr, req_wdata, mem_rdata, mem_ready,
        output gnt, done, err, rdata, mem_valid, mem_rw, mem_addr, mem_wdata
    );

    // Requesters plus memory FSM view.
    modport master (
        output req, req_rw, req_addr, req_wdata, mem_rdata, mem_ready,
        input  gnt, done, err, rdata, mem_valid, mem_rw, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [PTR_W-1:0] win_idx_o
);

    logic [PTR_W-1:0] pos;
    logic             found;

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        pos       = '0;
        found     = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            pos = PTR_W'((int'(ptr_i) + k) % int'(N_REQ));
            if (!found && req_i[pos]) begin
                found         = 1'b1;
                win_oh_o[pos] = 1'b1;
                win_idx_o     = pos;
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin sharing of one memory access port between N_REQ requesters.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    mem_access_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = clog2(N_REQ);
    localparam int unsigned CNT_W = clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [N_REQ-1:0]    arb_oh;
    logic [PTR_W-1:0]    arb_idx;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .win_oh_o  (arb_oh),
        .win_idx_o (arb_idx)
    );

    // State register and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= RW_WRITE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = '0;
        mem_valid_d = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    win_d   = arb_idx;
                    gnt_d   = arb_oh;
                end
            end
            GRANT: begin
                state_d     = ACCESS;
                mem_valid_d = 1'b1;
                cnt_d       = '0;
                mem_rw_d    = bus.req_rw[win_q];
                mem_addr_d  = bus.req_addr[int'(win_q)*ADDR_W +: ADDR_W];
                mem_wdata_d = bus.req_wdata[int'(win_q)*DATA_W +: DATA_W];
                ptr_d       = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
            end
            ACCESS: begin
                // A ready on the last allowed cycle still counts as success.
                if (bus.mem_ready) begin
                    state_d      = RESP;
                    cnt_d        = '0;
                    done_d[win_q] = 1'b1;
                    rdata_d      = (mem_rw_q == RW_READ) ? bus.mem_rdata : '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = RESP;
                    cnt_d        = '0;
                    done_d[win_q] = 1'b1;
                    err_d        = 1'b1;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    mem_valid_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: vector table, hand sequences, random traffic.
module tb_mem_access_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 15;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   ptr_m;

    mem_access_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_access_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] rw;
        logic [7:0] md;
        int         lat;
        bit         wd;
        bit         noise;
        int         ew;
        bit         ee;
        logic [7:0] er;
        int         ea;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(logic [3:0] req, logic [3:0] rw, logic [7:0] md, int lat,
                                bit wd, bit noise, int ew, bit ee, logic [7:0] er, int ea);
        vec_t v;
        v.req = req; v.rw = rw; v.md = md; v.lat = lat; v.wd = wd; v.noise = noise;
        v.ew = ew; v.ee = ee; v.er = er; v.ea = ea;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},       32'(bus.gnt),       32'h0);
        chk({tag, "_done"},      32'(bus.done),      32'h0);
        chk({tag, "_err"},       32'(bus.err),       32'h0);
        chk({tag, "_rdata"},     32'(bus.rdata),     32'h0);
        chk({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'h0);
        chk({tag, "_mem_rw"},    32'(bus.mem_rw),    32'h0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'h0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'h0);
    endtask

    // One transaction from an IDLE cycle; timeline derived from winner and ACCESS length ea.
    task automatic run_txn(input logic [3:0] rq, input logic [3:0] rw, input logic [31:0] af,
                           input logic [31:0] wf, input int lat, input logic [7:0] md,
                           input bit wd, input bit noise, input int ew, input bit ee,
                           input logic [7:0] er, input int ea);
        logic [3:0] oh;
        int         c;
        bus.req       = rq;
        bus.req_rw    = rw;
        bus.req_addr  = af;
        bus.req_wdata = wf;
        bus.mem_rdata = md;
        bus.mem_ready = noise;
        if (ew < 0) begin
            step();
            chk("idle_gnt",       32'(bus.gnt),       32'h0);
            chk("idle_mem_valid", 32'(bus.mem_valid), 32'h0);
            chk("idle_done",      32'(bus.done),      32'h0);
            bus.mem_ready = 1'b0;
            return;
        end
        oh = 4'b0001 << ew;
        for (int k = 0; k <= ea + 2; k++) begin
            if (k >= 2 && k <= ea + 1) bus.mem_ready = (k == lat + 2);
            else                       bus.mem_ready = noise;
            if (wd && k >= 2) bus.req = rq & ~oh;
            step();
            c = k + 1;
            chk("gnt", 32'(bus.gnt), (c == 1) ? 32'(oh) : 32'h0);
            chk("mem_valid", 32'(bus.mem_valid), 32'(c >= 2 && c <= ea + 1));
            if (c >= 2 && c <= ea + 1) begin
                chk("mem_rw",    32'(bus.mem_rw),    32'(rw[ew]));
                chk("mem_addr",  32'(bus.mem_addr),  32'(af[ew*AW +: AW]));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(wf[ew*DW +: DW]));
            end
            chk("done", 32'(bus.done), (c == ea + 2) ? 32'(oh) : 32'h0);
            if (c == ea + 2) begin
                chk("err",   32'(bus.err),   32'(ee));
                chk("rdata", 32'(bus.rdata), 32'(er));
            end
        end
        bus.mem_ready = 1'b0;
        ptr_m = (ew + 1) % N;
    endtask

    localparam logic [31:0] AF = 32'h40203C10;
    localparam logic [31:0] WF = 32'hD4C3B25A;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        ptr_m  = 0;
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;

        // Power-on reset.
        step();
        step();
        chk_all_zero("por");
        rst = 1'b0;

        // Reset in the middle of an access from requester 2.
        bus.req       = 4'b0100;
        bus.req_rw    = 4'b0100;
        bus.req_addr  = AF;
        bus.req_wdata = WF;
        step();
        step();
        step();
        chk("pre_rst_valid", 32'(bus.mem_valid), 32'h1);
        rst     = 1'b1;
        bus.req = '0;
        step();
        step();
        rst = 1'b0;
        chk_all_zero("mid_rst");
        step();
        chk("post_rst_gnt",   32'(bus.gnt),       32'h0);
        chk("post_rst_valid", 32'(bus.mem_valid), 32'h0);
        ptr_m = 0;

        // Vector table: {req, rw, mem_rdata, ready latency, withdraw, noise, winner, err, rdata, access cycles}.
        tbl[0] = mk(4'b1100, 4'b0100, 8'h66,  0, 0, 0,  2, 0, 8'h66,  1);
        tbl[1] = mk(4'b0010, 4'b0010, 8'hA5,  0, 0, 0,  1, 0, 8'hA5,  1);
        tbl[2] = mk(4'b0001, 4'b0000, 8'h77,  0, 0, 1,  0, 0, 8'h00,  1);
        tbl[3] = mk(4'b1111, 4'b1111, 8'hC3,  2, 0, 1,  1, 0, 8'hC3,  3);
        tbl[4] = mk(4'b1001, 4'b0000, 8'h99,  5, 1, 0,  3, 0, 8'h00,  6);
        tbl[5] = mk(4'b1001, 4'b1111, 8'h5E, 14, 0, 0,  0, 0, 8'h5E, 15);
        tbl[6] = mk(4'b0100, 4'b0100, 8'hE7, 15, 0, 1,  2, 1, 8'h00, 15);
        tbl[7] = mk(4'b0000, 4'b1111, 8'h00,  0, 0, 1, -1, 0, 8'h00,  0);
        tbl[8] = mk(4'b0011, 4'b0000, 8'h11, 20, 0, 0,  0, 1, 8'h00, 15);
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].req, tbl[i].rw, AF, WF, tbl[i].lat, tbl[i].md, tbl[i].wd,
                    tbl[i].noise, tbl[i].ew, tbl[i].ee, tbl[i].er, tbl[i].ea);
        end

        // Requester 3 withdraws after its grant; access still completes, then it is not re-granted.
        run_txn(4'b1000, 4'b1000, AF, WF, 1, 8'h3B, 1, 0, 3, 0, 8'h3B, 2);
        run_txn(4'b0000, 4'b0000, AF, WF, 0, 8'h00, 0, 0, -1, 0, 8'h00, 0);
        run_txn(4'b0110, 4'b0000, AF, WF, 0, 8'h12, 0, 0, 1, 0, 8'h00, 1);

        // All four requesting with mem_ready tied high: grants every 4 cycles in order 0,1,2,3,0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req       = 4'b1111;
        bus.req_rw    = 4'b1111;
        bus.mem_rdata = 8'h4D;
        bus.mem_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("rr_gnt", 32'(bus.gnt),
                (c % 4 == 1) ? (32'h1 << ((c / 4) % 4)) : 32'h0);
            chk("rr_done", 32'(bus.done),
                (c % 4 == 3) ? (32'h1 << (((c - 3) / 4) % 4)) : 32'h0);
            chk("rr_valid", 32'(bus.mem_valid), 32'(c % 4 == 2));
            if (c % 4 == 3) chk("rr_rdata", 32'(bus.rdata), 32'h4D);
            if (c == 19) bus.req = '0;
        end
        bus.mem_ready = 1'b0;
        ptr_m = 1;

        // Random traffic against the round-robin and timing rules.
        for (int r = 0; r < 60; r++) begin
            logic [3:0]  rq;
            logic [3:0]  rw;
            logic [31:0] af;
            logic [31:0] wf;
            logic [7:0]  md;
            int          lat;
            bit          wd;
            bit          noise;
            int          ew;
            bit          ee;
            logic [7:0]  er;
            int          ea;
            rq    = ($urandom % 4 == 0) ? 4'b0000 : 4'($urandom);
            rw    = 4'($urandom);
            af    = $urandom;
            wf    = $urandom;
            md    = 8'($urandom);
            lat   = int'($urandom_range(0, 17));
            wd    = ($urandom % 4 == 0);
            noise = 1'($urandom);
            ew = -1;
            for (int i = 0; i < N; i++) begin
                if (ew < 0 && rq[(ptr_m + i) % N]) ew = (ptr_m + i) % N;
            end
            ee = (lat >= TO);
            ea = ee ? TO : lat + 1;
            er = (ew >= 0 && !ee && rw[(ew < 0) ? 0 : ew]) ? md : 8'h00;
            run_txn(rq, rw, af, wf, lat, md, wd, noise, ew, ee, er, ea);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Shares one memory-access port between N_REQ requesters. Each requester posts a read or write. The block grants requesters in round-robin order, drives a single valid/rw strobe handshake toward the memory-side FSM, and returns completion, read data and timeout error to the winning requester. It sits between the bus masters and the memory access controller FSM, and is that FSM's only driver.

## Interface
- N_REQ, 4: number of requesters (2..8).
- ADDR_W, 8: address width.
- DATA_W, 8: data width.
- TIMEOUT, 15: maximum ACCESS cycles without mem_ready before the access is aborted (≥1).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; held until own done.
- req_rw  in  N_REQ  per-requester direction: 1 = read, 0 = write.
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  flattened write data, packed the same way.
- gnt  out  N_REQ  one-hot grant, high for the GRANT cycle only.
- done  out  N_REQ  one-hot completion pulse, one cycle.
- err  out  1  high with done when the access timed out.
- rdata  out  DATA_W  read data, valid while done is high.
- mem_valid  out  1  access strobe to the memory FSM.
- mem_rw  out  1  direction to the memory FSM, same encoding as req_rw.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready is high.
- mem_ready  in  1  memory completion, sampled only in ACCESS.

## Operation
- States: IDLE, GRANT, ACCESS, RESP.
- IDLE:
  - If any req bit is high, the round-robin arbiter picks a winner and the block moves to GRANT.
  - With no request, it stays in IDLE.
- GRANT:
  - gnt[winner] = 1.
  - req_rw, req_addr and req_wdata of the winner are latched into mem_rw, mem_addr and mem_wdata.
  - The round-robin pointer becomes winner+1 (mod N_REQ).
  - Next state: ACCESS.
- ACCESS:
  - mem_valid = 1, with mem_rw, mem_addr and mem_wdata stable.
  - The timeout counter increments each cycle.
  - mem_ready = 1 at a clock edge: capture mem_rdata (reads only; writes capture 0), go to RESP with err = 0.
  - Counter reaches TIMEOUT with no mem_ready: go to RESP with err = 1 and rdata = 0.
  - mem_ready arriving on the same edge the timeout expires counts as success.
- RESP:
  - done[winner] = 1, err and rdata valid.
  - Next state: IDLE.
- Round robin: search starts at the pointer and wraps modulo N_REQ; the first set req bit wins. After reset the pointer is 0.
- Withdrawing req after GRANT does not cancel the access. It completes on the latched fields and done is still pulsed.
- mem_ready outside ACCESS is ignored.
- req bits whose index is ≥ N_REQ do not exist; no masking is needed.

## Timing
- Reset values, applied on the rising edge with rst = 1 and overriding any state including mid-access:
  - state = IDLE, pointer = 0, counter = 0.
  - gnt = 0, done = 0, err = 0, rdata = 0.
  - mem_valid = 0, mem_rw = 0, mem_addr = 0, mem_wdata = 0.
- Request sampled in IDLE at edge t:
  - gnt during cycle t+1.
  - mem_valid from cycle t+2.
  - With mem_ready high at edge t+2, done during cycle t+3.
  - Back in IDLE at t+4.
- Minimum 4 cycles per transaction. A new arbitration happens only in IDLE, so the cycle after RESP can start the next grant.
- Timeout: mem_valid stays high for exactly TIMEOUT cycles, then RESP follows.
- All outputs are registered. There is no combinational path from req or mem_ready to any output.

## Structure
- Package mem_arb_pkg holds:
  - the state encoding (IDLE=2'b11, GRANT=2'b00, ACCESS=2'b01, RESP=2'b10, matching the memory FSM's idle-11 convention);
  - the RW_READ = 1 and RW_WRITE = 0 constants;
  - a clog2 function used for the counter and pointer widths.
- Sub-module rr_arbiter is combinational. It takes req and the pointer and returns a one-hot winner and its index. The top module holds the state register, the pointer, the counter and the datapath latches.

## Test plan
- Reset: assert rst for 2 cycles mid-ACCESS with mem_valid = 1 → next cycle every output is 0 and state is IDLE; a request from requester 2 then wins first.
- Single read: req[1]=1, req_rw[1]=1, addr 0x3C; mem_ready on first ACCESS cycle with mem_rdata = 0xA5 → gnt[1] at t+1, mem_valid at t+2, done[1] with rdata = 0xA5 and err = 0 at t+3.
- Single write: req[0]=1, rw = 0, addr 0x10, wdata 0x5A → mem_rw = 0, mem_wdata = 0x5A during ACCESS; done[0] with rdata = 0.
- Round robin: req = 4'b1111 held → grant order 0, 1, 2, 3, 0, one grant every 4 cycles with mem_ready tied high.
- Timeout: mem_ready held 0 → mem_valid high exactly 15 cycles, then done with err = 1 and rdata = 0. Repeat with mem_ready on cycle 15 → err = 0.
- Withdraw: req[3] dropped the cycle after gnt[3] → access completes and done[3] still pulses; next arbitration ignores requester 3.
